// File: rtl/hk_spi_slave.sv
// Housekeeping SPI slave (mode 0, MSB first), oversampled in the core clock domain, producing
// single-cycle register-bus strobes. Optional build macro: HK_SPI_BYTECNT_EN (N-byte limit).
module hk_spi_slave #(
   parameter int AW   = 8,
   parameter int DW   = 8,
   parameter int SYNC = 2
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          csb,
   input  logic          sck,
   input  logic          sdi,
   output logic          sdo,
   output logic          sdo_enb,
   output logic [AW-1:0] reg_addr,
   output logic [DW-1:0] reg_wdata,
   output logic          reg_we,
   output logic          reg_re,
   input  logic [DW-1:0] reg_rdata,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_ADDR,
      S_DATA,
      S_IGNORE,
      S_DONE
   } state_t;

   state_t          state, state_nx;

   logic [SYNC-1:0] csb_q, sck_q, sdi_q;
   logic            csb_s, sck_s, sdi_s;
   logic            csb_d, sck_d;
   logic            sck_rise, sck_fall, csb_fall;

   logic [2:0]      bit_cnt;
   logic [6:0]      rx_sr;
   logic [7:0]      rx_byte;
   logic            byte_done;

   logic            cmd_w, cmd_r;
   logic [AW-1:0]   addr_ptr;
`ifdef HK_SPI_BYTECNT_EN
   logic [2:0]      cmd_n;
   logic [2:0]      byte_cnt;
`endif

   logic            issue_re, issue_we, last_byte;
   logic [AW-1:0]   re_addr;
   logic            we_pend;
   logic [AW-1:0]   waddr_pend;
   logic [DW-1:0]   wdata_pend;
   logic            rd_cap;
   logic            rd_out;
   logic [DW-1:0]   tx_sr;

   // Pin synchronizers and edge detectors
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         // NOTE: csb chain resets to the idle level (1) so leaving reset cannot fake a csb fall.
         csb_q <= '1;
         sck_q <= '0;
         sdi_q <= '0;
         csb_d <= 1'b1;
         sck_d <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every stage sample its pre-edge neighbour,
         // so the chain advances exactly one flop per clock.
         csb_q <= {csb_q[SYNC-2:0], csb};
         sck_q <= {sck_q[SYNC-2:0], sck};
         sdi_q <= {sdi_q[SYNC-2:0], sdi};
         csb_d <= csb_s;
         sck_d <= sck_s;
      end
   end

   assign csb_s    = csb_q[SYNC-1];
   assign sck_s    = sck_q[SYNC-1];
   assign sdi_s    = sdi_q[SYNC-1];
   assign sck_rise = sck_s & ~sck_d;
   assign sck_fall = ~sck_s & sck_d;
   assign csb_fall = ~csb_s & csb_d;
   assign busy     = ~csb_s;

   assign rx_byte   = {rx_sr, sdi_s};
   assign byte_done = sck_rise && (bit_cnt == 3'd7);
   assign rd_out    = (state == S_DATA) && cmd_r;

   // Receive shifter; the counter restarts for every transaction
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bit_cnt <= '0;
         rx_sr   <= '0;
      end else if (state == S_IDLE) begin
         bit_cnt <= '0;
      end else if (sck_rise) begin
         bit_cnt <= bit_cnt + 3'd1;
         rx_sr   <= rx_byte[6:0];
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_nx  = state;
      issue_re  = 1'b0;
      issue_we  = 1'b0;
      last_byte = 1'b0;
      re_addr   = addr_ptr + AW'(1);
      unique case (state)
         S_IDLE: if (csb_fall) state_nx = S_CMD;
         S_CMD: begin
            if (byte_done) state_nx = (rx_byte[7:6] == 2'b00) ? S_IGNORE : S_ADDR;
         end
         S_ADDR: begin
            if (byte_done) begin
               state_nx = S_DATA;
               issue_re = cmd_r;
               re_addr  = AW'(rx_byte);
            end
         end
         S_DATA: begin
            if (byte_done) begin
`ifdef HK_SPI_BYTECNT_EN
               last_byte = (cmd_n != 3'd0) && (byte_cnt == cmd_n - 3'd1);
`endif
               if (last_byte) state_nx = S_DONE;
               issue_we = cmd_w;
               issue_re = cmd_r && !last_byte;
            end
         end
         default: ;
      endcase
      // Deselect wins over everything; a byte finishing on the same clock is dropped
      if (csb_s) begin
         state_nx = S_IDLE;
         issue_re = 1'b0;
         issue_we = 1'b0;
      end
   end

   // Command, address pointer and register-bus strobes
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cmd_w      <= 1'b0;
         cmd_r      <= 1'b0;
         addr_ptr   <= '0;
`ifdef HK_SPI_BYTECNT_EN
         cmd_n      <= '0;
         byte_cnt   <= '0;
`endif
         reg_re     <= 1'b0;
         reg_we     <= 1'b0;
         reg_addr   <= '0;
         reg_wdata  <= '0;
         we_pend    <= 1'b0;
         waddr_pend <= '0;
         wdata_pend <= '0;
         rd_cap     <= 1'b0;
      end else begin
         if (state == S_CMD && byte_done) begin
            cmd_w <= rx_byte[7];
            cmd_r <= rx_byte[6];
`ifdef HK_SPI_BYTECNT_EN
            cmd_n <= rx_byte[5:3];
`endif
         end
         if (state == S_ADDR && byte_done) begin
            addr_ptr <= AW'(rx_byte);
`ifdef HK_SPI_BYTECNT_EN
            byte_cnt <= '0;
`endif
         end else if (state == S_DATA && byte_done) begin
            addr_ptr <= addr_ptr + AW'(1);
`ifdef HK_SPI_BYTECNT_EN
            byte_cnt <= byte_cnt + 3'd1;
`endif
         end

         // Read+write: next-address read goes first, the write of this byte follows a clock later
         reg_re  <= issue_re;
         reg_we  <= (issue_we && !issue_re) || we_pend;
         we_pend <= issue_we && issue_re;
         rd_cap  <= reg_re;
         if (issue_we && issue_re) begin
            waddr_pend <= addr_ptr;
            wdata_pend <= DW'(rx_byte);
         end
         if (issue_re) begin
            reg_addr <= re_addr;
         end else if (issue_we) begin
            reg_addr  <= addr_ptr;
            reg_wdata <= DW'(rx_byte);
         end else if (we_pend) begin
            reg_addr  <= waddr_pend;
            reg_wdata <= wdata_pend;
         end
      end
   end

   // Transmit shifter; a load coinciding with an sck fall forwards the MSB straight to sdo
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tx_sr   <= '0;
         sdo     <= 1'b0;
         sdo_enb <= 1'b1;
      end else begin
         if (rd_cap) begin
            if (sck_fall && rd_out) begin
               sdo   <= reg_rdata[DW-1];
               tx_sr <= {reg_rdata[DW-2:0], 1'b0};
            end else begin
               tx_sr <= reg_rdata;
            end
         end else if (sck_fall && rd_out) begin
            sdo   <= tx_sr[DW-1];
            tx_sr <= {tx_sr[DW-2:0], 1'b0};
         end else if (state == S_IDLE) begin
            sdo <= 1'b0;
         end
         sdo_enb <= !((state_nx == S_DATA) && cmd_r);
      end
   end

endmodule
